// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: memory request/response channel and instruction-queue push channel.
// master = fetch sequencer, slave = memory controller / instruction queue side.
interface fetch_sequencer_if #(
   parameter int ADDR_WIDTH = 17,
   parameter int INST_WIDTH = 32
);
   logic                  mem_req;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_ready;
   logic                  mem_valid;
   logic [INST_WIDTH-1:0] mem_data;
   logic                  iq_full;
   logic                  iq_push;
   logic [INST_WIDTH-1:0] iq_inst;
   logic [ADDR_WIDTH-1:0] iq_pc;

   modport master (
      output mem_req, mem_addr, iq_push, iq_inst, iq_pc,
      input  mem_ready, mem_valid, mem_data, iq_full
   );

   modport slave (
      input  mem_req, mem_addr, iq_push, iq_inst, iq_pc,
      output mem_ready, mem_valid, mem_data, iq_full
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: one outstanding word fetch, push to instruction queue, redirect handling.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
//
// state   | meaning
// S_IDLE  | out of reset, waiting for first rdy
// S_REQ   | presenting mem_req at pc
// S_WAIT  | request accepted, waiting for mem_valid
// S_PUSH  | holding fetched instruction until queue accepts
// S_DRAIN | redirected with fetch in flight, discarding its response
module fetch_sequencer #(
   parameter int ADDR_WIDTH = 17,
   parameter int INST_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  redirect_en,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   fetch_sequencer_if.master     bus,
   output logic [31:0]           perf_fetch_cnt,
   output logic [31:0]           perf_stall_cnt
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_PUSH  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] pc;
   logic [INST_WIDTH-1:0] inst_q;
   logic [ADDR_WIDTH-1:0] redirect_tgt;
   logic                  push_fire;

   assign redirect_tgt = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
   // A redirect in PUSH kills the held instruction in the same cycle.
   assign push_fire    = rdy && (state == S_PUSH) && !bus.iq_full && !redirect_en;

   assign bus.mem_req  = rdy && (state == S_REQ);
   assign bus.mem_addr = pc;
   assign bus.iq_push  = push_fire;
   assign bus.iq_inst  = inst_q;
   assign bus.iq_pc    = pc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_IDLE;
         pc     <= '0;
         inst_q <= '0;
      end else if (rdy) begin
         if (redirect_en) begin
            pc <= redirect_tgt;
            case (state)
               S_REQ:           state <= bus.mem_ready ? S_DRAIN : S_REQ;
               S_WAIT, S_DRAIN: state <= bus.mem_valid ? S_REQ : S_DRAIN;
               default:         state <= S_REQ;
            endcase
         end else begin
            case (state)
               S_IDLE: state <= S_REQ;
               S_REQ: begin
                  if (bus.mem_ready) state <= S_WAIT;
               end
               S_WAIT: begin
                  if (bus.mem_valid) begin
                     inst_q <= bus.mem_data;
                     state  <= S_PUSH;
                  end
               end
               S_PUSH: begin
                  if (!bus.iq_full) begin
                     pc    <= pc + ADDR_WIDTH'(4);
                     state <= S_REQ;
                  end
               end
               S_DRAIN: begin
                  if (bus.mem_valid) state <= S_REQ;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (push_fire && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (rdy && (state == S_PUSH) && bus.iq_full && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;
`else
   assign perf_fetch_cnt = 32'd0;
   assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch sequencer that owns the fetch PC and drives it through the memory interface. It issues one word fetch at a time, waits for the returned instruction, and pushes it with its PC into the instruction queue. It handles back-pressure from a full queue and PC redirects from the commit/branch path, discarding any fetch already in flight. It sits between the program-counter datapath, the memory controller and the instruction queue.

## Interface
- ADDR_WIDTH, 17, fetch address width in bytes
- INST_WIDTH, 32, instruction width
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; low = hold all state
- redirect_en  in  1  redirect request, one-cycle pulse
- redirect_pc  in  ADDR_WIDTH  redirect target; bits [1:0] forced to 0
- mem_req  out  1  fetch request
- mem_addr  out  ADDR_WIDTH  fetch address, equals current PC
- mem_ready  in  1  memory accepts request this cycle
- mem_valid  in  1  returned instruction valid
- mem_data  in  INST_WIDTH  returned instruction
- iq_full  in  1  instruction queue cannot accept
- iq_push  out  1  push instruction to queue
- iq_inst  out  INST_WIDTH  pushed instruction
- iq_pc  out  ADDR_WIDTH  PC of pushed instruction
- perf_fetch_cnt  out  32  instructions pushed
- perf_stall_cnt  out  32  cycles in PUSH with iq_full high

## Operation
- States: IDLE, REQ, WAIT, PUSH, DRAIN. Reset: IDLE, pc=0, held instruction=0, counters=0; all outputs 0.
- IDLE -> REQ on first cycle with rdy=1.
- REQ: mem_req=1, mem_addr=pc. mem_ready=1 -> WAIT. Otherwise stay.
- WAIT: mem_valid=1 -> latch mem_data, go to PUSH.
- PUSH: iq_push = !iq_full; iq_inst/iq_pc = held instruction and pc. On push: pc <= pc+4 (mod 2^ADDR_WIDTH), go to REQ. If iq_full, stay.
- DRAIN: wait for the stale response; mem_valid=1 -> drop it, go to REQ.
- Redirect (takes priority over all other transitions, pc <= {redirect_pc[ADDR_WIDTH-1:2],2'b00}):
  - IDLE or PUSH: go to REQ. The held instruction is dropped and iq_push is forced to 0 that cycle.
  - REQ with mem_ready=0: go to REQ. The old request is withdrawn, and the new address is presented next cycle.
  - REQ with mem_ready=1: the request was accepted, so go to DRAIN.
  - WAIT with mem_valid=0: go to DRAIN.
  - WAIT with mem_valid=1: the response is dropped, go to REQ.
  - DRAIN with mem_valid=0: stay in DRAIN. With mem_valid=1: go to REQ.
- rdy=0: state, pc, held data and counters frozen. Outputs hold their values, except mem_req and iq_push, which are forced to 0. All inputs are ignored.
- At most one outstanding fetch at any time.

## Timing
- All state is registered. mem_req/mem_addr are decoded from registered state only. iq_push is combinational on iq_full.
- Redirect at cycle N with nothing outstanding: mem_req=1 with the new address at N+1.
- Request accepted at N, mem_valid at M≥N+1: iq_push at M+1 if the queue is not full, next mem_req at M+2.
- Steady state with 1-cycle memory: one instruction per 3 cycles.
- Asynchronous reset mid-operation: immediate return to reset values. Any outstanding memory response after reset release is not expected; the memory controller shares rst.

## Configuration
- FETCH_PERF_CNT_EN defined: perf_fetch_cnt increments on each iq_push; perf_stall_cnt increments on each PUSH cycle with rdy=1 and iq_full=1. Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- FETCH_PERF_CNT_EN undefined: no counter registers; both perf outputs are tied to 0.

## Test plan
- Reset, rdy=1, memory with mem_ready=1 and 1-cycle latency, iq_full=0 -> pushes pc 0x0, 0x4, 0x8 with the matching mem_data, each 3 cycles apart.
- Hold in PUSH with iq_full=1 for 5 cycles -> iq_push=0 and pc stays fixed during the hold; on release, a single push occurs; perf_stall_cnt=5 (with macro).
- Redirect to 0x103 while in WAIT, then mem_valid 2 cycles later -> the stale data is not pushed; the next mem_addr is 0x100; the pushed iq_pc is 0x100.
- Redirect to 0x200 in the same cycle as mem_valid -> the response is dropped; mem_req with 0x200 appears the next cycle; no DRAIN.
- Redirect in REQ with mem_ready=0, then in REQ with mem_ready=1 -> the first case restarts directly; the second goes through DRAIN.
- pc = 2^17-4 pushed -> next mem_addr is 0x0; rdy=0 for 3 cycles mid-WAIT -> no state change and mem_req=0.
